instruction_fetch: RTL

Program counter and instruction store that feeds the `Processor` control decoder. It holds a word-addressed program loaded through a write port. Under a valid/ready handshake it presents one 32-bit instruction at a time to the decoder. It takes the decoder's branch flags and the ALU zero flag back for the presented instruction to choose the next PC. It replaces the hand-driven instruction stimulus with a real fetch stage.

---
 rtl/instruction_fetch.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: word-addressed program store, PC and a valid/ready handshake
// that presents one instruction at a time to the control decoder.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned OFFSET_WIDTH = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    progWriteEnable,
  input  logic [ADDR_WIDTH-1:0]   progAddr,
  input  logic [31:0]             progData,
  output logic [31:0]             instruction,
  output logic                    instrValid,
  input  logic                    decodeReady,
  input  logic                    branchFlag,
  input  logic                    unconditionalBranchFlag,
  input  logic                    zeroFlag,
  input  logic [OFFSET_WIDTH-1:0] branchOffset,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic [15:0]             fetchCount,
  output logic                    busy
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_e;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]     instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  mem_we;
  logic                  accept;
  logic                  taken;
  logic [ADDR_WIDTH-1:0] off_ext;
  logic [ADDR_WIDTH-1:0] pc_step;

  // Program store write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[progAddr] <= progData;
    end
  end

  // Next-state, next-PC, capture and counter logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    accept   = instr_valid_q & decodeReady;
    taken    = unconditionalBranchFlag | (branchFlag & zeroFlag);
    off_ext  = ADDR_WIDTH'($signed(branchOffset));
    pc_step  = taken ? off_ext : ADDR_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        mem_we = progWriteEnable;
        if (run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_d = mem_q[pc_q];
        state_d = S_VALID;
      end
      S_VALID: begin
        if (accept) begin
          pc_d = pc_q + pc_step;
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    instr_valid_d = (state_d == S_VALID);
    busy_d        = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      count_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
    end
  end

  assign instruction = instr_q;
  assign instrValid  = instr_valid_q;
  assign pc          = pc_q;
  assign fetchCount  = count_q;
  assign busy        = busy_q;

endmodule
